vpe_tile_scheduler: RTL and testbench

Sequencer that drives Q/K tile fetches from the tile buffer into the VPE / stage-5 pipeline for one attention row-block. It reads one Q tile, streams `J_size` K tiles, and signals `issue` to the VPE with each. Credits bound the tiles in flight in the pipeline. It drains on stage-5 retirement and reports completion.

---
 rtl/vpe_sched_pkg.sv | 18 +
 rtl/credit_counter.sv | 48 ++++
 rtl/vpe_tile_scheduler.sv | 149 ++++++++++++++
 tb/tb_vpe_tile_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpe_sched_pkg.sv
// Shared types and defaults for the VPE tile scheduler and its credit counter.
package vpe_sched_pkg;

  localparam int DEF_PARA       = 8;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_PIPE_DEPTH = 4;

  typedef logic [DEF_PARA-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_Q   = 3'd1,
    ST_STREAM_K = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } sched_state_e;

endpackage

// File: rtl/credit_counter.sv
// Up/down count of K tiles granted but not yet retired. Flags describe the count
// after this cycle's update so the owner can register its outputs from them.
module credit_counter #(
  parameter int PIPE_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty,
  output logic underflow
);

  localparam int CW = $clog2(PIPE_DEPTH + 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          dec_ok;

  // A retire with nothing outstanding is dropped and reported instead.
  assign dec_ok    = dec && (count_reg != '0);
  assign underflow = dec && (count_reg == '0);

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && !dec_ok) begin
      count_next = count_reg + CW'(1);
    end else if (!inc && dec_ok) begin
      count_next = count_reg - CW'(1);
    end
  end

  assign full  = (count_next == CW'(PIPE_DEPTH));
  assign empty = (count_next == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/vpe_tile_scheduler.sv
// Sequencer for one attention row-block: one Q tile fetch, then J_size K tile
// fetches issued to the VPE, throttled by pipeline credits, then drain and done.
module vpe_tile_scheduler
  import vpe_sched_pkg::*;
#(
  parameter int para       = DEF_PARA,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [para-1:0]   J_size,
  input  logic [ADDR_W-1:0] q_base_i,
  input  logic [ADDR_W-1:0] k_base_i,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_q_sel_o,
  input  logic              rd_gnt_i,
  output logic              issue_o,
  output logic              last_o,
  output logic [para-1:0]   tile_idx_o,
  input  logic              retire_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [2:0] IDLE     = ST_IDLE;
  localparam logic [2:0] LOAD_Q   = ST_LOAD_Q;
  localparam logic [2:0] STREAM_K = ST_STREAM_K;
  localparam logic [2:0] DRAIN    = ST_DRAIN;
  localparam logic [2:0] DONE     = ST_DONE;

  logic [2:0]        state_reg;
  logic [2:0]        state_next;
  logic [para-1:0]   j_size_reg;
  logic [para-1:0]   idx_reg;
  logic [para-1:0]   j_last;
  logic [ADDR_W-1:0] k_base_reg;

  logic start_ok;
  logic q_xfer;
  logic k_xfer;
  logic k_last;
  logic full_next;
  logic empty_next;
  logic underflow;

  assign start_ok = (state_reg == IDLE) && start_i;
  assign q_xfer   = (state_reg == LOAD_Q) && rd_req_o && rd_gnt_i;
  assign k_xfer   = (state_reg == STREAM_K) && rd_req_o && rd_gnt_i;
  assign j_last   = j_size_reg - 1'b1;
  assign k_last   = (idx_reg == j_last);

  credit_counter #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .inc       (k_xfer),
    .dec       (retire_i),
    .full      (full_next),
    .empty     (empty_next),
    .underflow (underflow)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = (J_size == '0) ? DONE : LOAD_Q;
        end
      end
      LOAD_Q: begin
        if (q_xfer) begin
          state_next = STREAM_K;
        end
      end
      STREAM_K: begin
        if (k_xfer && k_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as soon as the credit count is about to read zero, so done_o
        // lands one cycle after the registered count reaches zero.
        if (empty_next) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      j_size_reg <= '0;
      idx_reg    <= '0;
      k_base_reg <= '0;
      rd_req_o   <= 1'b0;
      rd_addr_o  <= '0;
      rd_q_sel_o <= 1'b0;
      issue_o    <= 1'b0;
      last_o     <= 1'b0;
      tile_idx_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      busy_o     <= (state_next != IDLE);
      done_o     <= (state_reg == DONE);
      // Request is derived from the post-update credit count so the
      // registered output always reflects the registered count.
      rd_req_o   <= (state_next == LOAD_Q) ||
                    ((state_next == STREAM_K) && !full_next);
      rd_q_sel_o <= (state_next == LOAD_Q);
      issue_o    <= k_xfer;
      last_o     <= k_xfer && k_last;
      if (k_xfer) begin
        tile_idx_o <= idx_reg;
      end

      if (start_ok) begin
        j_size_reg <= J_size;
        k_base_reg <= k_base_i;
        idx_reg    <= '0;
        rd_addr_o  <= q_base_i;
      end else if (q_xfer) begin
        rd_addr_o  <= k_base_reg;
      end else if (k_xfer) begin
        rd_addr_o  <= rd_addr_o + 1'b1;
        idx_reg    <= idx_reg + 1'b1;
      end

      if (underflow) begin
        err_o <= 1'b1;
      end else if (start_ok) begin
        err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vpe_tile_scheduler.sv
// Self-checking bench for vpe_tile_scheduler: directed corner cases plus
// randomized jobs checked against a transaction-level model.
module tb_vpe_tile_scheduler;

  localparam int PD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  J_size = '0;
  logic [11:0] q_base_i = '0;
  logic [11:0] k_base_i = '0;
  logic        rd_req_o;
  logic [11:0] rd_addr_o;
  logic        rd_q_sel_o;
  logic        rd_gnt_i = 1'b0;
  logic        issue_o;
  logic        last_o;
  logic [7:0]  tile_idx_o;
  logic        retire_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int n_chk  = 0;
  int n_pass = 0;
  int kx;

  always #5 clk = ~clk;

  vpe_tile_scheduler #(
    .para       (8),
    .ADDR_W     (12),
    .PIPE_DEPTH (PD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .J_size     (J_size),
    .q_base_i   (q_base_i),
    .k_base_i   (k_base_i),
    .rd_req_o   (rd_req_o),
    .rd_addr_o  (rd_addr_o),
    .rd_q_sel_o (rd_q_sel_o),
    .rd_gnt_i   (rd_gnt_i),
    .issue_o    (issue_o),
    .last_o     (last_o),
    .tile_idx_o (tile_idx_o),
    .retire_i   (retire_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete job against a model built from transfer/retire counts.
  task automatic run_job(input int j, input logic [11:0] qb, input logic [11:0] kb,
                         input int gnt_pct, input int rmin, input int rmax);
    int          n, k_sent, retired, last_ret, next_due, e;
    bit          q_done, prev_req, prev_gnt, xfer, ret, done_cycle, exp_req;
    logic [11:0] prev_addr, exp_addr;
    int          pend[$];
    int          due[$];
    k_sent   = 0;
    retired  = 0;
    last_ret = (j == 0) ? 1 : -10;
    next_due = 0;
    q_done   = 0;
    prev_req = 0;
    prev_gnt = 0;
    prev_addr = '0;
    start_i  = 1'b1;
    J_size   = 8'(j);
    q_base_i = qb;
    k_base_i = kb;
    rd_gnt_i = 1'b0;
    retire_i = 1'b0;
    step();
    n = 1;
    start_i = 1'b0;
    while (1) begin
      if (pend.size() > 0) begin
        e = pend.pop_front();
        chk("issue", 32'(issue_o), 32'd1);
        chk("tile_idx", 32'(tile_idx_o), 32'(e));
        chk("last", 32'(last_o), 32'(e == j - 1));
        next_due = (n + $urandom_range(rmax, rmin) > next_due + 1) ?
                   n + int'($urandom_range(rmax, rmin)) : next_due + 1;
        due.push_back(next_due);
      end else begin
        chk("no_issue", 32'(issue_o), 32'd0);
      end
      done_cycle = (retired == j) && (n == last_ret + 1);
      chk("done", 32'(done_o), 32'(done_cycle));
      chk("err", 32'(err_o), 32'd0);
      if (prev_req && !prev_gnt) begin
        chk("req_hold", 32'(rd_req_o), 32'd1);
        chk("addr_hold", 32'(rd_addr_o), 32'(prev_addr));
      end
      exp_req  = 1'b0;
      exp_addr = '0;
      if (j > 0 && !q_done) begin
        exp_req  = 1'b1;
        exp_addr = qb;
      end else if (k_sent < j) begin
        exp_req  = (k_sent - retired) < PD;
        exp_addr = kb + 12'(k_sent);
      end
      chk("req", 32'(rd_req_o), 32'(exp_req));
      if (exp_req) begin
        chk("addr", 32'(rd_addr_o), 32'(exp_addr));
        chk("q_sel", 32'(rd_q_sel_o), 32'(!q_done));
      end
      if (done_cycle) begin
        chk("busy_end", 32'(busy_o), 32'd0);
        break;
      end
      chk("busy", 32'(busy_o), 32'd1);
      if (n > 3000) begin
        chk("timeout_done", 32'(done_o), 32'd1);
        break;
      end
      rd_gnt_i = ($urandom_range(99, 0) < gnt_pct);
      ret = (due.size() > 0) && (due[0] <= n);
      if (ret) void'(due.pop_front());
      retire_i = ret;
      // Occasional start while busy must be ignored.
      if ($urandom_range(19, 0) == 0) begin
        start_i  = 1'b1;
        J_size   = 8'($urandom);
        q_base_i = 12'($urandom);
        k_base_i = 12'($urandom);
      end else begin
        start_i = 1'b0;
      end
      prev_req  = rd_req_o;
      prev_gnt  = rd_gnt_i;
      prev_addr = rd_addr_o;
      xfer      = exp_req && rd_gnt_i;
      step();
      n++;
      if (xfer) begin
        if (!q_done) begin
          q_done = 1'b1;
        end else begin
          pend.push_back(k_sent);
          k_sent++;
        end
      end
      if (ret) begin
        retired++;
        if (retired == j) last_ret = n;
      end
    end
    start_i  = 1'b0;
    retire_i = 1'b0;
    rd_gnt_i = 1'b0;
    $display("job J=%0d q=%03h k=%03h gnt=%0d%% retire=%0d..%0d cycles=%0d",
             j, qb, kb, gnt_pct, rmin, rmax, n);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_req", 32'(rd_req_o), 32'd0);
    chk("rst_addr", 32'(rd_addr_o), 32'd0);
    chk("rst_idx", 32'(tile_idx_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_issue", 32'(issue_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    $display("reset checks complete");

    run_job(3, 12'h010, 12'h100, 100, 2, 2);
    run_job(0, 12'h055, 12'h300, 100, 1, 1);
    run_job(4, 12'h123, 12'hFFE, 100, 1, 3);

    // Credit stall, retire release, transfer+retire in one cycle.
    start_i  = 1'b1;
    J_size   = 8'd6;
    q_base_i = 12'h020;
    k_base_i = 12'h200;
    rd_gnt_i = 1'b1;
    retire_i = 1'b0;
    step();
    start_i = 1'b0;
    kx = 0;
    for (int i = 0; i < 12; i++) begin
      if (rd_req_o && rd_gnt_i && !rd_q_sel_o) kx++;
      step();
    end
    chk("stall_xfers", 32'(kx), 32'd4);
    chk("stall_req", 32'(rd_req_o), 32'd0);
    retire_i = 1'b1;
    step();
    retire_i = 1'b0;
    chk("release_req", 32'(rd_req_o), 32'd1);
    chk("release_addr", 32'(rd_addr_o), 32'h204);
    retire_i = 1'b1;
    step();
    retire_i = 1'b0;
    chk("same_issue", 32'(issue_o), 32'd1);
    chk("same_idx", 32'(tile_idx_o), 32'd4);
    chk("same_req", 32'(rd_req_o), 32'd1);
    chk("same_addr", 32'(rd_addr_o), 32'h205);
    step();
    chk("final_idx", 32'(tile_idx_o), 32'd5);
    chk("final_last", 32'(last_o), 32'd1);
    chk("drain_req", 32'(rd_req_o), 32'd0);
    step();
    chk("drain_hold", 32'(rd_req_o), 32'd0);
    retire_i = 1'b1;
    repeat (4) step();
    retire_i = 1'b0;
    chk("credit_busy", 32'(busy_o), 32'd1);
    chk("credit_predone", 32'(done_o), 32'd0);
    step();
    chk("credit_done", 32'(done_o), 32'd1);
    chk("credit_err", 32'(err_o), 32'd0);
    $display("credit stall sequence complete");

    // Asynchronous reset in the middle of streaming K tiles.
    start_i  = 1'b1;
    J_size   = 8'd10;
    q_base_i = 12'h040;
    k_base_i = 12'h400;
    rd_gnt_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (3) step();
    chk("pre_rst_req", 32'(rd_req_o), 32'd1);
    chk("pre_rst_idx", 32'(tile_idx_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", 32'(rd_req_o), 32'd0);
    chk("arst_addr", 32'(rd_addr_o), 32'd0);
    chk("arst_idx", 32'(tile_idx_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_issue", 32'(issue_o), 32'd0);
    #3 rst = 1'b1;
    rd_gnt_i = 1'b0;
    step();
    retire_i = 1'b1;
    step();
    retire_i = 1'b0;
    chk("idle_retire_err", 32'(err_o), 32'd1);
    chk("idle_retire_busy", 32'(busy_o), 32'd0);
    $display("async reset and idle retire sequence complete");

    // The first job after the error must clear it.
    run_job(2, 12'h0AA, 12'h0BB, 100, 1, 2);

    for (int t = 0; t < 12; t++) begin
      run_job(int'($urandom_range(20, 1)), 12'($urandom), 12'($urandom),
              int'($urandom_range(100, 30)), 1, int'($urandom_range(6, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
